// File: rtl/row_pixel_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : row_pixel_serializer_if
//  Description : Row-in / pixel-out bus for the row pixel serializer.
//                row_in/row_valid/row_ready carry one packed image row,
//                pix_* carry one {R,G,B} pixel per transfer with
//                start-of-line, end-of-line and end-of-frame flags, and
//                row_idx gives the row number of the presented pixel.
//                master : the environment (row source and pixel sink)
//                slave  : the serializer
//  Revision    : 1.0  initial release
// ============================================================================
interface row_pixel_serializer_if #(
    parameter int COL   = 256,
    parameter int ROW   = 256,
    parameter int WIDTH = 8
);
    localparam int PIX_W = 3 * WIDTH;
    localparam int IDX_W = (ROW > 1) ? $clog2(ROW) : 1;

    logic [COL*PIX_W-1:0] row_in;
    logic                 row_valid;
    logic                 row_ready;
    logic [PIX_W-1:0]     pix_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_sol;
    logic                 pix_eol;
    logic                 pix_eof;
    logic [IDX_W-1:0]     row_idx;

    modport master (
        output row_in, row_valid, pix_ready,
        input  row_ready, pix_data, pix_valid, pix_sol, pix_eol, pix_eof, row_idx
    );

    modport slave (
        input  row_in, row_valid, pix_ready,
        output row_ready, pix_data, pix_valid, pix_sol, pix_eol, pix_eof, row_idx
    );
endinterface
`default_nettype wire

// File: rtl/row_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : row_pixel_serializer
//  Description : Unpacks a full image row into one RGB pixel per cycle.
//                A single-row holding buffer is reloaded on the same edge
//                that consumes the last pixel of the current row, so a
//                continuous row supply yields COL pixels per COL cycles.
//  Ports       : CLK  - clock, rising edge
//                RST  - synchronous active-high reset
//                bus  - row_pixel_serializer_if.slave
//                       row_in/row_valid/row_ready : packed row input
//                       pix_data/pix_valid/pix_ready : pixel output
//                       pix_sol/pix_eol/pix_eof : line/frame flags
//                       row_idx : row number of presented pixel
//  Revision    : 1.0  initial release
// ============================================================================
module row_pixel_serializer #(
    parameter int COL   = 256,
    parameter int ROW   = 256,
    parameter int WIDTH = 8
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    row_pixel_serializer_if.slave  bus
);
    localparam int c_PIX_W = 3 * WIDTH;
    localparam int c_COL_W = (COL > 1) ? $clog2(COL) : 1;
    localparam int c_IDX_W = (ROW > 1) ? $clog2(ROW) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COL - 1);
    localparam logic [c_IDX_W-1:0] c_ROW_LAST = c_IDX_W'(ROW - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]             r_state;
    logic [COL*c_PIX_W-1:0] r_buf;
    logic [c_COL_W-1:0]     r_col;
    logic [c_IDX_W-1:0]     r_row;

    logic                   w_valid;
    logic                   w_last;
    logic                   w_consume;
    logic                   w_row_ready;
    logic                   w_take;
    logic [c_PIX_W-1:0]     w_pix [COL];

    // Pixel j sits at the top of the packed row for j=0, descending.
    for (genvar j = 0; j < COL; j++) begin : g_unpack
        assign w_pix[j] = r_buf[(COL-j)*c_PIX_W-1 -: c_PIX_W];
    end

    // Outputs are forced quiet for the whole time reset is asserted, not
    // just after the first reset edge.
    assign w_valid   = !RST && (r_state == c_SEND);
    assign w_last    = (r_col == c_COL_LAST);
    assign w_consume = w_valid && bus.pix_ready;

    // Ready also opens on the last-pixel consume so the next row can be
    // loaded on that same edge without a bubble.
    assign w_row_ready = !RST && ((r_state == c_IDLE) ||
                                  ((r_state == c_SEND) && w_last && bus.pix_ready));
    assign w_take      = bus.row_valid && w_row_ready;

    assign bus.row_ready = w_row_ready;
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = w_valid ? w_pix[r_col] : '0;
    assign bus.pix_sol   = w_valid && (r_col == '0);
    assign bus.pix_eol   = w_valid && w_last;
    assign bus.pix_eof   = w_valid && w_last && (r_row == c_ROW_LAST);
    assign bus.row_idx   = w_valid ? r_row : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            if (w_take) begin
                r_state <= c_SEND;
                r_col   <= '0;
            end else if (w_consume) begin
                if (w_last) begin
                    r_state <= c_IDLE;
                end else begin
                    r_col <= r_col + c_COL_W'(1);
                end
            end

            if (w_consume && w_last) begin
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_IDX_W'(1);
            end
        end
    end

    // Buffer contents are don't-care outside SEND, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (w_take) begin
            r_buf <= bus.row_in;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_row_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_pixel_serializer
//  Description : Self-checking bench for row_pixel_serializer (COL=4, ROW=2,
//                WIDTH=8). A queue of pending pixels models the buffer; every
//                cycle all outputs are compared against the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_row_pixel_serializer;
    localparam int COL   = 4;
    localparam int ROW   = 2;
    localparam int WIDTH = 8;
    localparam int PW    = 3 * WIDTH;
    localparam int RW    = COL * PW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    row_pixel_serializer_if #(.COL(COL), .ROW(ROW), .WIDTH(WIDTH)) bus ();

    row_pixel_serializer #(.COL(COL), .ROW(ROW), .WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic          sol;
        logic          eol;
        logic          eof;
        logic [0:0]    idx;
    } pix_t;

    pix_t          q[$];
    int            rows_done = 0;
    bit            took;
    int            total = 0;
    int            bad   = 0;
    bit            want_en = 1'b0;
    logic [PW-1:0] want;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_row(input logic [RW-1:0] rd);
        pix_t e;
        for (int j = 0; j < COL; j++) begin
            e.d   = PW'(rd >> ((COL - 1 - j) * PW));
            e.sol = (j == 0);
            e.eol = (j == COL - 1);
            e.eof = (j == COL - 1) && (rows_done == ROW - 1);
            e.idx = 1'(rows_done);
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        logic er;
        pix_t e;
        ev = !rst && (q.size() > 0);
        er = !rst && ((q.size() == 0) || ((q.size() == 1) && bus.pix_ready));
        e  = ev ? q[0] : '0;
        chk("pix_valid", 32'(bus.pix_valid), 32'(ev));
        chk("row_ready", 32'(bus.row_ready), 32'(er));
        chk("pix_data",  32'(bus.pix_data),  32'(e.d));
        chk("pix_sol",   32'(bus.pix_sol),   32'(e.sol));
        chk("pix_eol",   32'(bus.pix_eol),   32'(e.eol));
        chk("pix_eof",   32'(bus.pix_eof),   32'(e.eof));
        chk("row_idx",   32'(bus.row_idx),   32'(e.idx));
        if (want_en) chk("directed_pixel", 32'(bus.pix_data), 32'(want));
    endtask

    // One clock: drive inputs, check mid-cycle, then advance the model on
    // the rising edge using the driven inputs and model state only.
    task automatic cyc(input logic r, input logic rv, input logic [RW-1:0] rd, input logic pr);
        logic rr;
        rst           = r;
        bus.row_valid = rv;
        bus.row_in    = rd;
        bus.pix_ready = pr;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        took = 1'b0;
        if (r) begin
            q.delete();
            rows_done = 0;
        end else begin
            rr = (q.size() == 0) || ((q.size() == 1) && pr);
            if ((q.size() > 0) && pr) begin
                if (q[0].eol) rows_done = (rows_done + 1) % ROW;
                void'(q.pop_front());
            end
            if (rv && rr) begin
                push_row(rd);
                took = 1'b1;
            end
        end
        #1;
    endtask

    function automatic logic [RW-1:0] rnd_row();
        return {$urandom, $urandom, $urandom};
    endfunction

    localparam logic [RW-1:0] R1 = 96'h112233_445566_778899_AABBCC;

    initial begin
        logic [PW-1:0]  exp1 [COL];
        logic [RW-1:0]  rows [3];
        int             k;

        exp1[0] = 24'h112233; exp1[1] = 24'h445566;
        exp1[2] = 24'h778899; exp1[3] = 24'hAABBCC;

        // Reset
        cyc(1, 0, '0, 0);
        cyc(1, 1, R1, 1);

        // 1: single row, sink always ready
        cyc(0, 1, R1, 1);
        for (int j = 0; j < COL; j++) begin
            want_en = 1'b1;
            want    = exp1[j];
            cyc(0, 0, '0, 1);
        end
        want_en = 1'b0;
        cyc(0, 0, '0, 1);

        // 2: rows offered back-to-back, row_valid held high
        cyc(1, 0, '0, 0);
        rows[0] = rnd_row(); rows[1] = rnd_row(); rows[2] = rnd_row();
        k = 0;
        for (int c = 0; c < 15; c++) begin
            cyc(0, (k < 3), rows[(k < 3) ? k : 0], 1);
            if (took) k++;
        end

        // 3: stall for 5 cycles while pixel 1 is presented
        cyc(1, 0, '0, 0);
        cyc(0, 1, R1, 1);
        cyc(0, 0, '0, 1);
        for (int c = 0; c < 5; c++) begin
            want_en = 1'b1;
            want    = 24'h445566;
            cyc(0, 0, '0, 0);
        end
        want_en = 1'b0;
        for (int c = 0; c < 4; c++) cyc(0, 0, '0, 1);

        // 4: reset mid-row after pixel 2 is consumed
        cyc(0, 1, R1, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        cyc(1, 0, '0, 1);
        cyc(0, 0, '0, 0);
        cyc(0, 1, rnd_row(), 1);
        for (int c = 0; c < 5; c++) cyc(0, 0, '0, 1);

        // 5: row offered while SEND and sink stalled
        cyc(0, 1, R1, 1);
        for (int c = 0; c < 3; c++) cyc(0, 1, rnd_row(), 0);
        for (int c = 0; c < 6; c++) cyc(0, 0, '0, 1);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 500; c++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                rnd_row(), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
